// File: rtl/alu_pkg.sv
// Shared constants for the ALU decode/operand-fetch stage: widths, instruction
// field positions and the opcode/condition/shift-control codes.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 3;
  localparam int unsigned NREGS  = 1 << REG_AW;

  localparam int unsigned COND_HI  = 31;
  localparam int unsigned COND_LO  = 28;
  localparam int unsigned OP_HI    = 27;
  localparam int unsigned OP_LO    = 24;
  localparam int unsigned S_BIT    = 23;
  localparam int unsigned INSTC_BIT = 22;
  localparam int unsigned SR_HI    = 21;
  localparam int unsigned SR_LO    = 19;
  localparam int unsigned RD_HI    = 18;
  localparam int unsigned RD_LO    = 16;
  localparam int unsigned RN_HI    = 15;
  localparam int unsigned RN_LO    = 13;
  localparam int unsigned RM_HI    = 12;
  localparam int unsigned RM_LO    = 10;
  localparam int unsigned SH_HI    = 9;
  localparam int unsigned SH_LO    = 5;
  localparam int unsigned IMM_HI   = 15;
  localparam int unsigned IMM_LO   = 0;

  localparam logic [3:0] OP_CMP  = 4'b1000;
  localparam logic [3:0] COND_AL = 4'b0000;

  typedef enum logic [2:0] {
    SR_NONE = 3'b000,
    SR_LSL  = 3'b001,
    SR_LSR  = 3'b010,
    SR_ROR  = 3'b011
  } srcon_e;

endpackage

// File: rtl/alu_decode_stage_if.sv
// Issue handshake, writeback and ALU-bound output bundle of the decode stage.
interface alu_decode_stage_if;
  import alu_pkg::*;

  logic [31:0]         i_instr;
  logic                i_instr_valid;
  logic                o_instr_ready;
  logic                i_wb_en;
  logic [REG_AW-1:0]   i_wb_addr;
  logic [DATA_W-1:0]   i_wb_data;
  logic                o_valid;
  logic [3:0]          o_Cond;
  logic [3:0]          o_OP;
  logic                o_S;
  logic                o_instc;
  logic [2:0]          o_SRcon;
  logic [4:0]          o_shiftamt;
  logic [15:0]         o_imval;
  logic [DATA_W-1:0]   o_in1;
  logic [DATA_W-1:0]   o_in2;
  logic [REG_AW-1:0]   o_rd;
  logic                o_wr;

  modport master (
    output i_instr, i_instr_valid, i_wb_en, i_wb_addr, i_wb_data,
    input  o_instr_ready, o_valid, o_Cond, o_OP, o_S, o_instc, o_SRcon,
           o_shiftamt, o_imval, o_in1, o_in2, o_rd, o_wr
  );

  modport slave (
    input  i_instr, i_instr_valid, i_wb_en, i_wb_addr, i_wb_data,
    output o_instr_ready, o_valid, o_Cond, o_OP, o_S, o_instc, o_SRcon,
           o_shiftamt, o_imval, o_in1, o_in2, o_rd, o_wr
  );
endinterface

// File: rtl/alu_regfile.sv
// 8x32 register file: one synchronous write port, two asynchronous read ports
// that return the write data when reading the register being written.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (we && (waddr == raddr_a)) ? wdata : regs[raddr_a];
  assign rdata_b = (we && (waddr == raddr_b)) ? wdata : regs[raddr_b];

endmodule

// File: rtl/alu_decode_stage.sv
// Decode/operand-fetch stage ahead of the ALU: splits the instruction word,
// reads operands, tracks in-flight destinations and registers the ALU bundle.
module alu_decode_stage
  import alu_pkg::*;
(
  input  logic               Clk,
  input  logic               Rst,
  alu_decode_stage_if.slave  bus
);

  logic [REG_AW-1:0] rd, rn, rm, src_a;
  logic              instc, wr, hazard, issue;
  logic [NREGS-1:0]  pending, pend_eff, wb_mask;
  logic [DATA_W-1:0] rdata_a, rdata_b;

  assign rd    = bus.i_instr[RD_HI:RD_LO];
  assign rn    = bus.i_instr[RN_HI:RN_LO];
  assign rm    = bus.i_instr[RM_HI:RM_LO];
  assign instc = bus.i_instr[INSTC_BIT];
  assign wr    = (bus.i_instr[OP_HI:OP_LO] != OP_CMP);
  // Immediate form is two-address: Rd is both source and destination.
  assign src_a = instc ? rd : rn;

  // A bit cleared by this cycle's writeback is already treated as free.
  always_comb begin
    wb_mask = '0;
    if (bus.i_wb_en) wb_mask[bus.i_wb_addr] = 1'b1;
    pend_eff = pending & ~wb_mask;
    hazard   = pend_eff[src_a] | (!instc & pend_eff[rm]) | (wr & pend_eff[rd]);
  end

  assign bus.o_instr_ready = !Rst && !hazard;
  assign issue             = bus.i_instr_valid && bus.o_instr_ready;

  alu_regfile u_regfile (
    .clk     (Clk),
    .rst     (Rst),
    .we      (bus.i_wb_en),
    .waddr   (bus.i_wb_addr),
    .wdata   (bus.i_wb_data),
    .raddr_a (src_a),
    .raddr_b (rm),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  // Set after clear so a same-cycle issue to the written index stays pending.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~wb_mask) | ((issue && wr) ? (NREGS'(1) << rd) : '0);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      bus.o_valid    <= 1'b0;
      bus.o_Cond     <= '0;
      bus.o_OP       <= '0;
      bus.o_S        <= 1'b0;
      bus.o_instc    <= 1'b0;
      bus.o_SRcon    <= '0;
      bus.o_shiftamt <= '0;
      bus.o_imval    <= '0;
      bus.o_in1      <= '0;
      bus.o_in2      <= '0;
      bus.o_rd       <= '0;
      bus.o_wr       <= 1'b0;
    end else if (issue) begin
      bus.o_valid    <= 1'b1;
      bus.o_Cond     <= bus.i_instr[COND_HI:COND_LO];
      bus.o_OP       <= bus.i_instr[OP_HI:OP_LO];
      bus.o_S        <= bus.i_instr[S_BIT];
      bus.o_instc    <= instc;
      bus.o_SRcon    <= bus.i_instr[SR_HI:SR_LO];
      bus.o_shiftamt <= instc ? '0 : bus.i_instr[SH_HI:SH_LO];
      bus.o_imval    <= instc ? bus.i_instr[IMM_HI:IMM_LO] : '0;
      bus.o_in1      <= instc ? '0 : rdata_b;
      bus.o_in2      <= rdata_a;
      bus.o_rd       <= rd;
      bus.o_wr       <= wr;
    end else begin
      bus.o_valid    <= 1'b0;
      bus.o_S        <= 1'b0;
      bus.o_wr       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed vector table for the hazard/bypass/reset
// corners, then random traffic checked against a field-level reference model.
module tb_alu_decode_stage;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  alu_decode_stage_if bus ();

  alu_decode_stage dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  typedef struct {
    logic        valid;
    logic [3:0]  cond;
    logic [3:0]  op;
    logic        s;
    logic        instc;
    logic [2:0]  srcon;
    logic [4:0]  sh;
    logic [15:0] imv;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [2:0]  rd;
    logic        wr;
  } out_t;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        vld;
    logic        wbe;
    logic [2:0]  wba;
    logic [31:0] wbd;
    logic        rdy;
    logic        ov;
    logic        chk;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [2:0]  rd;
    logic        wr;
    logic        s;
    logic [15:0] imv;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] m_regs [8];
  bit          m_pend [8];
  out_t        m_out;
  logic        last_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_r(logic [3:0] cond, logic [3:0] op, logic s,
                                       logic [2:0] sr, logic [2:0] rd, logic [2:0] rn,
                                       logic [2:0] rm, logic [4:0] sh);
    return {cond, op, s, 1'b0, sr, rd, rn, rm, sh, 5'b0};
  endfunction

  function automatic logic [31:0] mk_i(logic [3:0] cond, logic [3:0] op, logic s,
                                       logic [2:0] sr, logic [2:0] rd, logic [15:0] imm);
    return {cond, op, s, 1'b1, sr, rd, imm};
  endfunction

  // Ready rule: every register the instruction reads or writes must be free,
  // where a register being written back this cycle counts as free.
  function automatic bit m_hazard(logic [31:0] ins, logic wbe, logic [2:0] wba);
    bit p [8];
    int rd = int'(ins[18:16]);
    int rn = int'(ins[15:13]);
    int rm = int'(ins[12:10]);
    p = m_pend;
    if (wbe) p[wba] = 1'b0;
    if (ins[22]) return p[rd];
    return p[rn] || p[rm] || ((ins[27:24] != 4'd8) && p[rd]);
  endfunction

  function automatic logic [31:0] m_read(int idx, logic wbe, logic [2:0] wba, logic [31:0] wbd);
    if (wbe && int'(wba) == idx) return wbd;
    return m_regs[idx];
  endfunction

  task automatic step(input logic rst, input logic [31:0] ins, input logic vld,
                      input logic wbe, input logic [2:0] wba, input logic [31:0] wbd);
    bit issue;
    Rst               = rst;
    bus.i_instr       = ins;
    bus.i_instr_valid = vld;
    bus.i_wb_en       = wbe;
    bus.i_wb_addr     = wba;
    bus.i_wb_data     = wbd;
    #1;
    last_rdy = !rst && !m_hazard(ins, wbe, wba);
    chk("ready", bus.o_instr_ready, last_rdy);
    @(posedge Clk);
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_out = '{default: '0};
    end else begin
      issue = vld && last_rdy;
      if (issue) begin
        m_out.valid = 1'b1;
        m_out.cond  = ins[31:28];
        m_out.op    = ins[27:24];
        m_out.s     = ins[23];
        m_out.instc = ins[22];
        m_out.srcon = ins[21:19];
        m_out.rd    = ins[18:16];
        m_out.wr    = (ins[27:24] != 4'd8);
        if (ins[22]) begin
          m_out.imv = ins[15:0];
          m_out.sh  = '0;
          m_out.in1 = '0;
          m_out.in2 = m_read(int'(ins[18:16]), wbe, wba, wbd);
        end else begin
          m_out.imv = '0;
          m_out.sh  = ins[9:5];
          m_out.in1 = m_read(int'(ins[12:10]), wbe, wba, wbd);
          m_out.in2 = m_read(int'(ins[15:13]), wbe, wba, wbd);
        end
      end else begin
        m_out.valid = 1'b0;
        m_out.s     = 1'b0;
        m_out.wr    = 1'b0;
      end
      if (wbe) m_pend[wba] = 1'b0;
      if (issue && m_out.wr) m_pend[ins[18:16]] = 1'b1;
      if (wbe) m_regs[wba] = wbd;
    end
    #1;
    chk("o_valid",    bus.o_valid,    m_out.valid);
    chk("o_Cond",     bus.o_Cond,     m_out.cond);
    chk("o_OP",       bus.o_OP,       m_out.op);
    chk("o_S",        bus.o_S,        m_out.s);
    chk("o_instc",    bus.o_instc,    m_out.instc);
    chk("o_SRcon",    bus.o_SRcon,    m_out.srcon);
    chk("o_shiftamt", bus.o_shiftamt, m_out.sh);
    chk("o_imval",    bus.o_imval,    m_out.imv);
    chk("o_in1",      bus.o_in1,      m_out.in1);
    chk("o_in2",      bus.o_in2,      m_out.in2);
    chk("o_rd",       bus.o_rd,       m_out.rd);
    chk("o_wr",       bus.o_wr,       m_out.wr);
  endtask

  function automatic vec_t v(logic rst, logic [31:0] ins, logic vld, logic wbe,
                             logic [2:0] wba, logic [31:0] wbd, logic rdy, logic ov,
                             logic chk_on, logic [31:0] in1, logic [31:0] in2,
                             logic [2:0] rd, logic wr, logic s, logic [15:0] imv);
    vec_t r;
    r.rst = rst; r.instr = ins; r.vld = vld; r.wbe = wbe; r.wba = wba; r.wbd = wbd;
    r.rdy = rdy; r.ov = ov; r.chk = chk_on; r.in1 = in1; r.in2 = in2; r.rd = rd;
    r.wr = wr; r.s = s; r.imv = imv;
    return r;
  endfunction

  vec_t tbl [$];

  initial begin
    m_out = '{default: '0};
    foreach (m_regs[i]) m_regs[i] = '0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;

    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 2, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, mk_r(0, 0, 0, 0, 3, 2, 1, 0), 1, 0, 0, 0, 1, 1, 1, 7, 4, 3, 1, 0, 0));
    tbl.push_back(v(0, mk_r(0, 0, 0, 0, 5, 3, 1, 0), 1, 0, 0, 0, 0, 0, 1, 7, 4, 3, 0, 0, 0));
    tbl.push_back(v(0, mk_r(0, 0, 0, 0, 5, 3, 1, 0), 1, 1, 3, 11, 1, 1, 1, 7, 11, 5, 1, 0, 0));
    tbl.push_back(v(0, mk_i(0, 0, 0, 0, 2, 16'h0010), 1, 1, 5, 9, 1, 1, 1, 0, 4, 2, 1, 0, 16'h0010));
    tbl.push_back(v(0, mk_r(0, 4'b1000, 1, 0, 0, 1, 2, 0), 1, 1, 2, 4, 1, 1, 1, 4, 7, 0, 0, 1, 0));
    tbl.push_back(v(0, mk_r(0, 1, 0, 0, 1, 0, 0, 0), 1, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(0, mk_r(0, 2, 0, 0, 4, 0, 0, 0), 1, 1, 1, 20, 1, 1, 1, 0, 0, 4, 1, 0, 0));
    tbl.push_back(v(0, mk_r(0, 3, 0, 0, 4, 0, 0, 0), 1, 0, 0, 0, 0, 0, 1, 0, 0, 4, 0, 0, 0));
    tbl.push_back(v(0, mk_r(0, 3, 0, 0, 4, 0, 0, 0), 1, 1, 4, 5, 1, 1, 1, 0, 0, 4, 1, 0, 0));
    tbl.push_back(v(0, mk_r(0, 0, 0, 0, 6, 4, 1, 0), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, mk_r(0, 0, 0, 0, 7, 1, 2, 0), 1, 0, 0, 0, 1, 1, 1, 4, 20, 7, 1, 0, 0));
    tbl.push_back(v(1, mk_r(0, 0, 0, 0, 5, 0, 0, 0), 1, 1, 3, 99, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, mk_r(0, 0, 0, 0, 4, 1, 2, 0), 1, 0, 0, 0, 1, 1, 1, 0, 0, 4, 1, 0, 0));
    tbl.push_back(v(0, mk_i(0, 0, 0, 0, 7, 16'hffff), 1, 0, 0, 0, 1, 1, 1, 0, 0, 7, 1, 0, 16'hffff));

    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].instr, tbl[k].vld, tbl[k].wbe, tbl[k].wba, tbl[k].wbd);
      chk($sformatf("vec%0d_ready", k), last_rdy, tbl[k].rdy);
      chk($sformatf("vec%0d_valid", k), bus.o_valid, tbl[k].ov);
      if (tbl[k].chk) begin
        chk($sformatf("vec%0d_in1", k),   bus.o_in1,   tbl[k].in1);
        chk($sformatf("vec%0d_in2", k),   bus.o_in2,   tbl[k].in2);
        chk($sformatf("vec%0d_rd", k),    bus.o_rd,    tbl[k].rd);
        chk($sformatf("vec%0d_wr", k),    bus.o_wr,    tbl[k].wr);
        chk($sformatf("vec%0d_S", k),     bus.o_S,     tbl[k].s);
        chk($sformatf("vec%0d_imval", k), bus.o_imval, tbl[k].imv);
      end
    end

    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 63) == 0, $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
